// File: rtl/usb_sie_rx_os.sv
// Oversampling USB SIE receiver: glitch filter, phase tracking, NRZI decode, unstuff, SYNC/EOP.
// Define USB_SIE_RX_BUS_RESET_EN to build the long-SE0 bus-reset detector.
package usb_sie_rx_pkg;
  typedef logic [7:0] bus8_t;
endpackage

module usb_sie_rx_os
  import usb_sie_rx_pkg::*;
#(
  parameter int OSR        = 4,
  parameter int LOW_SPEED  = 0,
  parameter int RESET_BITS = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  dn_rx,
  input  logic  dp_rx,
  input  logic  tx_active,
  output bus8_t rx_data,
  output logic  rx_valid,
  output logic  rx_active,
  output logic  rx_error,
  output logic  bus_reset
);

  localparam logic [1:0] LS_J   = (LOW_SPEED != 0) ? 2'b10 : 2'b01;
  localparam logic [1:0] LS_K   = (LOW_SPEED != 0) ? 2'b01 : 2'b10;
  localparam int         PH_W   = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_STB = PH_W'((OSR - 1) / 2);
  localparam logic [7:0] SYNC   = 8'h80;

  if (OSR < 3 || RESET_BITS < 1) begin : g_param_chk
    $error("usb_sie_rx_os: OSR must be >= 3 and RESET_BITS >= 1");
  end

  typedef enum logic [1:0] {IDLE, DATA, ABORT} state_t;

  logic [1:0] line_p0, line_p1, raw_p1, cand_p2, line_st;
  logic       accept;
  logic [PH_W-1:0] phase;
  logic       strobe, is_j, is_k, is_se0;

  // SE1 is folded into SE0 before filtering
  assign raw_p1 = (line_p1 == 2'b11) ? 2'b00 : line_p1;
  assign accept = (raw_p1 == cand_p2) && (raw_p1 != line_st);

  // Stage p0/p1: two-flop synchroniser; p2: glitch-filter candidate and accepted state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_p0 <= LS_J;
      line_p1 <= LS_J;
      cand_p2 <= LS_J;
      line_st <= LS_J;
    end else begin
      line_p0 <= {dn_rx, dp_rx};
      line_p1 <= line_p0;
      cand_p2 <= raw_p1;
      if (accept) line_st <= raw_p1;
    end
  end

  // Phase counter realigns on every accepted edge so the strobe stays mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  phase <= '0;
    else if (accept)          phase <= '0;
    else if (phase == PH_MAX) phase <= '0;
    else                      phase <= phase + PH_W'(1);
  end

  assign is_j   = (line_st == LS_J);
  assign is_k   = (line_st == LS_K);
  assign is_se0 = !(is_j || is_k);
  assign strobe = (phase == PH_STB) && !tx_active;

  state_t     state, state_nxt;
  logic [1:0] prev_st, prev_nxt;
  logic       se0_seen, se0_nxt;
  logic [2:0] ones, ones_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [2:0] jcnt, jcnt_nxt;
  logic [7:0] shift, shift_nxt, shifted;
  bus8_t      data_nxt;
  logic       valid_nxt, error_nxt;
  logic       bit_val, bit_en, eop, bus_rst_hit;

  assign bit_val = (line_st == prev_st);
  // The J that closes an EOP is not a data bit
  assign bit_en  = strobe && !is_se0 && !(se0_seen && is_j);
  assign eop     = strobe && se0_seen && is_j;
  assign shifted = {bit_val, shift[7:1]};

  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev_st;
    se0_nxt    = se0_seen;
    ones_nxt   = ones;
    bitcnt_nxt = bitcnt;
    jcnt_nxt   = jcnt;
    shift_nxt  = shift;
    data_nxt   = rx_data;
    valid_nxt  = 1'b0;
    error_nxt  = 1'b0;

    if (strobe) begin
      se0_nxt  = is_se0;
      prev_nxt = is_se0 ? LS_J : line_st;
      jcnt_nxt = is_j ? jcnt + 3'd1 : 3'd0;
    end

    case (state)
      IDLE: begin
        ones_nxt = 3'd0;
        if (bit_en) begin
          shift_nxt = shifted;
          if (shifted == SYNC) begin
            state_nxt  = DATA;
            bitcnt_nxt = 3'd0;
          end
        end
      end
      DATA: begin
        if (eop) begin
          state_nxt = IDLE;
          error_nxt = (bitcnt != 3'd0);
        end else if (bit_en) begin
          if (ones == 3'd6) begin
            ones_nxt = 3'd0;
            if (bit_val) begin
              error_nxt = 1'b1;
              state_nxt = ABORT;
              jcnt_nxt  = 3'd0;
            end
          end else begin
            ones_nxt   = bit_val ? ones + 3'd1 : 3'd0;
            shift_nxt  = shifted;
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              data_nxt  = shifted;
              valid_nxt = 1'b1;
            end
          end
        end
      end
      ABORT: begin
        if (eop || (strobe && is_j && jcnt == 3'd7)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (bus_rst_hit && state != IDLE) state_nxt = IDLE;

    if (tx_active) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      error_nxt = 1'b0;
    end

    if (state_nxt == IDLE && state != IDLE) begin
      shift_nxt = 8'hFF;
      ones_nxt  = 3'd0;
    end
  end

  // Stage p3: decoder state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev_st   <= LS_J;
      se0_seen  <= 1'b0;
      ones      <= 3'd0;
      bitcnt    <= 3'd0;
      jcnt      <= 3'd0;
      shift     <= 8'hFF;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_st   <= prev_nxt;
      se0_seen  <= se0_nxt;
      ones      <= ones_nxt;
      bitcnt    <= bitcnt_nxt;
      jcnt      <= jcnt_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      rx_error  <= error_nxt;
      rx_active <= (state_nxt != IDLE);
    end
  end

`ifdef USB_SIE_RX_BUS_RESET_EN
  localparam int RST_MAX = RESET_BITS * OSR;
  localparam int RC_W    = $clog2(RST_MAX + 1);

  logic [RC_W-1:0] rst_cnt, rst_cnt_nxt;

  function automatic logic [RC_W-1:0] sat_inc(input logic [RC_W-1:0] v);
    return (v == RC_W'(RST_MAX)) ? v : v + RC_W'(1);
  endfunction

  assign rst_cnt_nxt = is_se0 ? sat_inc(rst_cnt) : '0;
  assign bus_rst_hit = (rst_cnt == RC_W'(RST_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt   <= '0;
      bus_reset <= 1'b0;
    end else begin
      rst_cnt   <= rst_cnt_nxt;
      bus_reset <= (rst_cnt_nxt == RC_W'(RST_MAX));
    end
  end
`else
  assign bus_rst_hit = 1'b0;
  assign bus_reset   = 1'b0;
`endif

endmodule

// File: tb/tb_usb_sie_rx_os.sv
// Bench for usb_sie_rx_os (OSR=4, full speed): table-driven packets with a byte scoreboard,
// plus hand-written tx_active, mid-packet reset and long-SE0 sequences.
module tb_usb_sie_rx_os;
  logic       clk = 1'b0;
  logic       rst;
  logic       dn_rx, dp_rx, tx_active;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error, bus_reset;

  localparam logic [1:0] ST_J = 2'b01, ST_K = 2'b10, ST_SE0 = 2'b00;
`ifdef USB_SIE_RX_BUS_RESET_EN
  localparam logic BR_EN = 1'b1;
`else
  localparam logic BR_EN = 1'b0;
`endif

  usb_sie_rx_os #(.OSR(4), .LOW_SPEED(0), .RESET_BITS(32)) dut (
    .clk(clk), .rst(rst), .dn_rx(dn_rx), .dp_rx(dp_rx), .tx_active(tx_active),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_error(rx_error), .bus_reset(bus_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          jit;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          nerr;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         n_cmp = 0, n_fail = 0, v_seen = 0, e_seen = 0;
  logic [1:0] lvl;
  bit         alt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [1:0] st);
    {dn_rx, dp_rx} = st;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic [1:0] st, input bit jit);
    put(st);
    if (jit) begin
      alt = !alt;
      hold(alt ? 5 : 3);
    end else begin
      hold(4);
    end
  endtask

  task automatic nrzi(input logic b, input bit jit);
    if (!b) lvl = (lvl == ST_J) ? ST_K : ST_J;
    bit_time(lvl, jit);
  endtask

  task automatic send_sync(input bit jit);
    logic [7:0] s;
    s   = 8'h80;
    lvl = ST_J;
    for (int i = 0; i < 8; i++) nrzi(s[i], jit);
  endtask

  task automatic send_eop(input bit jit);
    bit_time(ST_SE0, jit);
    bit_time(ST_SE0, jit);
    lvl = ST_J;
    bit_time(ST_J, jit);
    put(ST_J);
    hold(32);
  endtask

  // Scoreboard: every rx_valid pops the next expected byte
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        v_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got rx_data=%0h, want no strobe", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (rx_error) e_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{bits: 32'h000000A5, nbits: 8,  jit: 1'b0, nbytes: 1, b0: 8'hA5, b1: 8'h00, nerr: 0};
    vecs[1] = '{bits: 32'h0003DFBF, nbits: 18, jit: 1'b0, nbytes: 2, b0: 8'hFF, b1: 8'hFF, nerr: 0};
    vecs[2] = '{bits: 32'h0000007F, nbits: 7,  jit: 1'b0, nbytes: 0, b0: 8'h00, b1: 8'h00, nerr: 1};
    vecs[3] = '{bits: 32'h0000053C, nbits: 12, jit: 1'b0, nbytes: 1, b0: 8'h3C, b1: 8'h00, nerr: 1};
    vecs[4] = '{bits: 32'h0000005A, nbits: 8,  jit: 1'b1, nbytes: 1, b0: 8'h5A, b1: 8'h00, nerr: 0};
    vecs[5] = '{bits: 32'h00008100, nbits: 16, jit: 1'b0, nbytes: 2, b0: 8'h00, b1: 8'h81, nerr: 0};

    rst       = 1'b1;
    tx_active = 1'b0;
    put(ST_J);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data",   {24'h0, rx_data}, 32'h0);
    check("rst_rx_valid",  {31'h0, rx_valid}, 32'h0);
    check("rst_rx_active", {31'h0, rx_active}, 32'h0);
    check("rst_rx_error",  {31'h0, rx_error}, 32'h0);
    check("rst_bus_reset", {31'h0, bus_reset}, 32'h0);
    rst = 1'b0;
    hold(16);

    for (int i = 0; i < 6; i++) begin
      v_seen = 0;
      e_seen = 0;
      exp_q.delete();
      if (vecs[i].nbytes > 0) exp_q.push_back(vecs[i].b0);
      if (vecs[i].nbytes > 1) exp_q.push_back(vecs[i].b1);
      alt = 1'b0;
      send_sync(vecs[i].jit);
      for (int k = 0; k < vecs[i].nbits; k++) nrzi(vecs[i].bits[k], vecs[i].jit);
      check($sformatf("v%0d_active_in_pkt", i), {31'h0, rx_active}, 32'h1);
      send_eop(vecs[i].jit);
      check($sformatf("v%0d_valid_count", i), v_seen, vecs[i].nbytes);
      check($sformatf("v%0d_error_count", i), e_seen, vecs[i].nerr);
      check($sformatf("v%0d_active_after_eop", i), {31'h0, rx_active}, 32'h0);
      check($sformatf("v%0d_queue_left", i), exp_q.size(), 0);
    end

    // tx_active mid-packet: drop to idle one clock later, silently
    v_seen = 0;
    e_seen = 0;
    exp_q.delete();
    send_sync(1'b0);
    nrzi(1'b1, 1'b0);
    nrzi(1'b0, 1'b0);
    nrzi(1'b1, 1'b0);
    check("txa_active_before", {31'h0, rx_active}, 32'h1);
    tx_active = 1'b1;
    hold(1);
    check("txa_active_drop", {31'h0, rx_active}, 32'h0);
    nrzi(1'b0, 1'b0);
    nrzi(1'b0, 1'b0);
    nrzi(1'b1, 1'b0);
    nrzi(1'b1, 1'b0);
    nrzi(1'b0, 1'b0);
    send_eop(1'b0);
    tx_active = 1'b0;
    hold(16);
    check("txa_valid_count", v_seen, 0);
    check("txa_error_count", e_seen, 0);
    check("txa_active_end", {31'h0, rx_active}, 32'h0);

    // Asynchronous reset mid-packet
    v_seen = 0;
    e_seen = 0;
    send_sync(1'b0);
    nrzi(1'b1, 1'b0);
    nrzi(1'b0, 1'b0);
    nrzi(1'b1, 1'b0);
    nrzi(1'b0, 1'b0);
    check("rstm_active_before", {31'h0, rx_active}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("rstm_active_now", {31'h0, rx_active}, 32'h0);
    check("rstm_data_now", {24'h0, rx_data}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nrzi(1'b1, 1'b0);
    nrzi(1'b1, 1'b0);
    nrzi(1'b0, 1'b0);
    nrzi(1'b1, 1'b0);
    send_eop(1'b0);
    check("rstm_valid_count", v_seen, 0);
    check("rstm_error_count", e_seen, 0);
    check("rstm_active_end", {31'h0, rx_active}, 32'h0);

    // Long SE0: accepted 4 clocks after the drive, bus_reset 128 clocks after that
    v_seen = 0;
    e_seen = 0;
    put(ST_SE0);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 4)   check("br_early",   {31'h0, bus_reset}, 32'h0);
      if (k == 131) check("br_pre_sat", {31'h0, bus_reset}, 32'h0);
      if (k == 132) check("br_sat",     {31'h0, bus_reset}, {31'h0, BR_EN});
      if (k == 200) check("br_held",    {31'h0, bus_reset}, {31'h0, BR_EN});
    end
    put(ST_J);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) check("br_before_fall", {31'h0, bus_reset}, {31'h0, BR_EN});
      if (k == 5) check("br_fall",        {31'h0, bus_reset}, 32'h0);
    end
    hold(16);
    check("br_error_count", e_seen, 0);
    check("br_valid_count", v_seen, 0);
    check("br_active", {31'h0, rx_active}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
